// File: rtl/keccak_pkg.sv
// keccak_pkg: lane width and Keccak state type shared by the Keccak blocks
package keccak_pkg;
  parameter int N = 64;
  typedef logic [4:0][4:0][N-1:0] state;
endpackage

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: emits rate lanes of permuted states, requesting new permutations until out_len lanes are out
module keccak_squeeze #(
  parameter int N = keccak_pkg::N,
  parameter int RATE_LANES = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        out_len,
  input  keccak_pkg::state  st_in,
  input  logic              st_valid,
  output logic              st_ready,
  output logic              perm_req,
  output logic [N-1:0]      dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);
  localparam int W = RATE_LANES > 1 ? $clog2(RATE_LANES) : 1;
  localparam logic [W-1:0] LAST = W'(RATE_LANES - 1);
  typedef enum logic [1:0] {IDLE, WAIT_ST, EMIT, REQ} state_t;
  state_t state_q, state_d;
  logic [7:0] rem_q, rem_d;
  logic [W-1:0] idx_q, idx_d;
  logic [RATE_LANES-1:0][N-1:0] buf_q, buf_d;
  logic done_q, done_d;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    idx_d = idx_q;
    buf_d = buf_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (out_len != 8'd0) begin
          rem_d = out_len;
          state_d = WAIT_ST;
        end else done_d = 1'b1;
      end
      WAIT_ST: if (st_valid) begin
        for (int i = 0; i < RATE_LANES; i++) buf_d[i] = st_in[i/5][i%5];
        idx_d = '0;
        state_d = EMIT;
      end
      EMIT: if (dout_ready) begin
        rem_d = rem_q - 8'd1;
        idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
        // job end wins over the rate boundary so no trailing perm_req
        if (rem_q == 8'd1) begin
          done_d = 1'b1;
          state_d = IDLE;
        end else if (idx_q == LAST) state_d = REQ;
      end
      REQ: state_d = WAIT_ST;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q <= '0;
      idx_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
      done_q <= done_d;
    end
  end
  assign st_ready = state_q == WAIT_ST;
  assign perm_req = state_q == REQ;
  assign dout_valid = state_q == EMIT;
  assign dout = dout_valid ? buf_q[idx_q] : '0;
  assign dout_last = dout_valid && rem_q == 8'd1;
  assign busy = state_q != IDLE;
  assign done = done_q;
endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze: directed job table plus hand-written backpressure, zero-length and reset sequences
module tb_keccak_squeeze;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] out_len = '0;
  keccak_pkg::state st_in, st_a, st_b;
  logic st_valid = 1'b0;
  logic st_ready, perm_req, dout_valid, dout_last, busy, done;
  logic dout_ready = 1'b0;
  logic [63:0] dout;
  int checks = 0;
  int errors = 0;

  keccak_squeeze dut (
    .clk(clk), .rst_n(rst_n), .start(start), .out_len(out_len),
    .st_in(st_in), .st_valid(st_valid), .st_ready(st_ready), .perm_req(perm_req),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int perms;
  } job_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane(input int k);
    logic [7:0] b;
    logic [63:0] v;
    b = 8'(k % 17 + 1);
    v = {8{b}};
    return ((k / 17) % 2 == 1) ? ~v : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 1 applies the ready pattern 0,0,1,0,1,1 over EMIT cycles; mid_start pokes start during EMIT
  task automatic run_job(input int len, input int exp_perms, input int mode, input bit mid_start);
    int k, perms, cyc, e;
    logic pat [6];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    k = 0; perms = 0; cyc = 0; e = 0;
    start = 1'b1; out_len = 8'(len);
    tick();
    start = 1'b0;
    st_valid = 1'b1;
    while (k < len && cyc < 300) begin
      st_in = (perms % 2 == 1) ? st_b : st_a;
      dout_ready = (mode == 1 && e < 6) ? pat[e] : 1'b1;
      start = mid_start && dout_valid && k == 1;
      out_len = start ? 8'd9 : out_len;
      #1;
      chk("busy", 64'(busy), 64'd1);
      if (perm_req) perms++;
      if (dout_valid) begin
        chk($sformatf("lane%0d", k), dout, lane(k));
        chk($sformatf("last%0d", k), 64'(dout_last), 64'(k == len - 1));
        if (dout_ready) k++;
        e++;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    st_valid = 1'b0;
    dout_ready = 1'b0;
    chk("timeout", 64'(cyc < 300), 64'd1);
    chk("done", 64'(done), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(dout_valid), 64'd0);
    chk("perms", 64'(perms), 64'(exp_perms));
    tick();
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    job_t jobs [6];
    jobs = '{'{4, 0}, '{20, 1}, '{17, 0}, '{1, 0}, '{35, 2}, '{34, 1}};
    for (int i = 0; i < 25; i++) st_a[i/5][i%5] = i < 17 ? {8{8'(i + 1)}} : 64'hA5A5_0000_0000_0000 | 64'(i);
    st_b = ~st_a;
    st_in = st_a;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd0);
    chk("rst_perm", 64'(perm_req), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_st_ready", 64'(st_ready), 64'd0);
    for (int j = 0; j < 6; j++) run_job(jobs[j].len, jobs[j].perms, 0, 1'b0);
    run_job(3, 0, 1, 1'b0);
    run_job(5, 0, 0, 1'b1);
    // zero-length job
    start = 1'b1; out_len = 8'd0;
    tick();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    tick();
    chk("zero_done_pulse", 64'(done), 64'd0);
    chk("zero_busy2", 64'(busy), 64'd0);
    // reset during lane 2 of a 10-lane job
    start = 1'b1; out_len = 8'd10; st_in = st_a;
    tick();
    start = 1'b0; st_valid = 1'b1;
    chk("wait_st_ready", 64'(st_ready), 64'd1);
    tick();
    st_valid = 1'b0; dout_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_lane2", dout, lane(2));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(dout_valid), 64'd0);
    chk("mid_rst_dout", dout, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_last", 64'(dout_last), 64'd0);
    dout_ready = 1'b0;
    tick();
    chk("rst_hold_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    run_job(1, 0, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
